// File: rtl/gate_response_checker_if.sv
// Handshake and result bundle between a gate-response checker and its driver/gate under test.
interface gate_response_checker_if;
    logic       start;
    logic [1:0] op;
    logic       a_out;
    logic       b_out;
    logic       f_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_count;
    logic [3:0] err_mask;
    logic [1:0] case_idx;

    modport master (
        output start, op, f_in,
        input  a_out, b_out, busy, done, pass, fail_count, err_mask, case_idx
    );

    modport slave (
        input  start, op, f_in,
        output a_out, b_out, busy, done, pass, fail_count, err_mask, case_idx
    );
endinterface

// File: rtl/gate_response_checker.sv
// Exhaustive 2-input gate checker: drives AB = 00..11, waits SETTLE_CYCLES, compares f_in to the selected function.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN ends the run at the first mismatching case.
module gate_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic             clk,
    input logic             reset,
    gate_response_checker_if.slave io
);
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned CASE_W     = 2;
    localparam int unsigned FAIL_W     = 3;
    localparam int unsigned CASE_N     = 4;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CASE_W-1:0] CASE_LAST   = CASE_W'(CASE_N - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(CASE_N);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state,      state_nxt;
    logic [CASE_W-1:0]   case_q,     case_nxt;
    logic [CNT_W-1:0]    cnt_q,      cnt_nxt;
    logic [FAIL_W-1:0]   fail_q,     fail_nxt;
    logic [CASE_N-1:0]   err_q,      err_nxt;
    logic [1:0]          op_q,       op_nxt;
    logic                a_q,        a_nxt;
    logic                b_q,        b_nxt;
    logic                busy_q,     busy_nxt;
    logic                done_q,     done_nxt;
    logic                pass_q,     pass_nxt;
    logic                expected_c;
    logic                mismatch_c;

    // Reference function of the gate selected at start.
    always_comb begin
        expected_c = 1'b0;
        case (op_q)
            2'b00:   expected_c = a_q & b_q;
            2'b01:   expected_c = a_q | b_q;
            2'b10:   expected_c = a_q ^ b_q;
            default: expected_c = ~(a_q & b_q);
        endcase
    end

    // Case-equality so an X/Z response never counts as a match.
    assign mismatch_c = !(io.f_in === expected_c);

    always_comb begin
        state_nxt = state;
        case_nxt  = case_q;
        cnt_nxt   = cnt_q;
        fail_nxt  = fail_q;
        err_nxt   = err_q;
        op_nxt    = op_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        pass_nxt  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (io.start) begin
                    state_nxt = DRIVE;
                    case_nxt  = '0;
                    fail_nxt  = '0;
                    err_nxt   = '0;
                    op_nxt    = io.op;
                end
            end
            DRIVE: begin
                state_nxt = SETTLE;
                cnt_nxt   = '0;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    if (fail_q < FAIL_MAX) begin
                        fail_nxt = FAIL_W'(fail_q + FAIL_W'(1));
                    end
                    err_nxt[case_q] = 1'b1;
                end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                if (case_q == CASE_LAST || mismatch_c) begin
`else
                if (case_q == CASE_LAST) begin
`endif
                    state_nxt = DONE;
                end else begin
                    state_nxt = DRIVE;
                    case_nxt  = CASE_W'(case_q + CASE_W'(1));
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Operands are loaded on entry to DRIVE so they are valid for the whole case.
        if (state_nxt == DRIVE) begin
            a_nxt = case_nxt[1];
            b_nxt = case_nxt[0];
        end

        busy_nxt = (state_nxt == DRIVE) || (state_nxt == SETTLE) || (state_nxt == SAMPLE);
        done_nxt = (state == DONE) && !io.start;
        pass_nxt = done_nxt && (fail_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            case_q <= '0;
            cnt_q  <= '0;
            fail_q <= '0;
            err_q  <= '0;
            op_q   <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            case_q <= case_nxt;
            cnt_q  <= cnt_nxt;
            fail_q <= fail_nxt;
            err_q  <= err_nxt;
            op_q   <= op_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            pass_q <= pass_nxt;
        end
    end

    assign io.a_out      = a_q;
    assign io.b_out      = b_q;
    assign io.busy       = busy_q;
    assign io.done       = done_q;
    assign io.pass       = pass_q;
    assign io.fail_count = fail_q;
    assign io.err_mask   = err_q;
    assign io.case_idx   = case_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (SETTLE_CYCLES 1 and 3) against a truth-table reference model.
module tb_gate_response_checker;
    localparam int MAX_CYC = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [3:0] gate_tbl;
    int         checks   = 0;
    int         failures = 0;

    gate_response_checker_if ifc1 ();
    gate_response_checker_if ifc3 ();

    assign ifc1.start = start;
    assign ifc1.op    = op;
    assign ifc1.f_in  = gate_tbl[{ifc1.a_out, ifc1.b_out}];
    assign ifc3.start = start;
    assign ifc3.op    = op;
    assign ifc3.f_in  = gate_tbl[{ifc3.a_out, ifc3.b_out}];

    gate_response_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .io(ifc1));
    gate_response_checker #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .io(ifc3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Truth table of each function, bit i = output for AB = i.
    function automatic logic [3:0] ideal_table(input logic [1:0] o);
        case (o)
            2'b00:   return 4'b1000;
            2'b01:   return 4'b1110;
            2'b10:   return 4'b0110;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a1"},    8'(ifc1.a_out), 8'h0);
        chk({tag, "_b1"},    8'(ifc1.b_out), 8'h0);
        chk({tag, "_busy1"}, 8'(ifc1.busy), 8'h0);
        chk({tag, "_done1"}, 8'(ifc1.done), 8'h0);
        chk({tag, "_pass1"}, 8'(ifc1.pass), 8'h0);
        chk({tag, "_fc1"},   8'(ifc1.fail_count), 8'h0);
        chk({tag, "_err1"},  8'(ifc1.err_mask), 8'h0);
        chk({tag, "_idx1"},  8'(ifc1.case_idx), 8'h0);
        chk({tag, "_busy3"}, 8'(ifc3.busy), 8'h0);
        chk({tag, "_done3"}, 8'(ifc3.done), 8'h0);
        chk({tag, "_fc3"},   8'(ifc3.fail_count), 8'h0);
        chk({tag, "_err3"},  8'(ifc3.err_mask), 8'h0);
    endtask

    // One full run on both instances; optionally re-pulse start and flip op mid-run.
    task automatic run_case(input string tag, input logic [1:0] op_v, input logic [3:0] tbl,
                            input bit disturb);
        logic [3:0] errs, exp_err;
        logic [2:0] exp_fail;
        int         last, lat1, lat3;
        logic [7:0] seq1, seq3, exp_seq;
        logic [2:0] prev1, prev3;

        errs     = tbl ^ ideal_table(op_v);
        last     = 3;
        exp_err  = errs;
        exp_fail = 3'($countones(errs));
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        for (int i = 3; i >= 0; i--) begin
            if (errs[i]) last = i;
        end
        if (errs != 4'b0) begin
            exp_err  = 4'(1 << last);
            exp_fail = 3'd1;
        end
`endif
        exp_seq = '0;
        for (int i = 0; i <= last; i++) exp_seq = {exp_seq[5:0], 2'(i)};

        gate_tbl = tbl;
        op       = op_v;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat1 = 0; lat3 = 0;
        seq1 = '0; seq3 = '0;
        prev1 = 3'b100; prev3 = 3'b100;
        for (int c = 1; c <= MAX_CYC && (lat1 == 0 || lat3 == 0); c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                chk({tag, "_busy1_c1"}, 8'(ifc1.busy), 8'h1);
                chk({tag, "_busy3_c1"}, 8'(ifc3.busy), 8'h1);
            end
            if (ifc1.busy && {1'b0, ifc1.a_out, ifc1.b_out} != prev1) begin
                seq1  = {seq1[5:0], ifc1.a_out, ifc1.b_out};
                prev1 = {1'b0, ifc1.a_out, ifc1.b_out};
            end
            if (ifc3.busy && {1'b0, ifc3.a_out, ifc3.b_out} != prev3) begin
                seq3  = {seq3[5:0], ifc3.a_out, ifc3.b_out};
                prev3 = {1'b0, ifc3.a_out, ifc3.b_out};
            end
            if (ifc1.done && lat1 == 0) lat1 = c;
            if (ifc3.done && lat3 == 0) lat3 = c;
            if (disturb) begin
                start = (c == 3 || c == 7);
                if (c == 3 || c == 7) op = ~op;
            end
        end
        start = 1'b0;

        chk({tag, "_lat1"},  8'(lat1), 8'(1 + (last + 1) * 3));
        chk({tag, "_lat3"},  8'(lat3), 8'(1 + (last + 1) * 5));
        chk({tag, "_seq1"},  seq1, exp_seq);
        chk({tag, "_seq3"},  seq3, exp_seq);
        chk({tag, "_ab1"},   8'({ifc1.a_out, ifc1.b_out}), 8'(last));
        chk({tag, "_done1"}, 8'(ifc1.done), 8'h1);
        chk({tag, "_fc1"},   8'(ifc1.fail_count), 8'(exp_fail));
        chk({tag, "_fc3"},   8'(ifc3.fail_count), 8'(exp_fail));
        chk({tag, "_err1"},  8'(ifc1.err_mask), 8'(exp_err));
        chk({tag, "_err3"},  8'(ifc3.err_mask), 8'(exp_err));
        chk({tag, "_pass1"}, 8'(ifc1.pass), 8'(exp_fail == 3'd0));
        chk({tag, "_pass3"}, 8'(ifc3.pass), 8'(exp_fail == 3'd0));
        chk({tag, "_idx1"},  8'(ifc1.case_idx), 8'(last));
        chk({tag, "_idx3"},  8'(ifc3.case_idx), 8'(last));
    endtask

    initial begin
        int done_seen;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        gate_tbl = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        reset = 1'b0;
        @(posedge clk); #1;

        run_case("and_ideal",   2'b00, ideal_table(2'b00), 1'b0);
        run_case("xor_as_and",  2'b10, ideal_table(2'b00), 1'b0);
        run_case("or_disturb",  2'b01, ideal_table(2'b01), 1'b1);
        run_case("nand_ideal",  2'b11, ideal_table(2'b11), 1'b0);
        run_case("nand_rerun",  2'b11, ideal_table(2'b11), 1'b0);
        run_case("or_stuck0",   2'b01, 4'b0000, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_case($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)));
        end

        // Abandon a run with reset and make sure nothing completes afterwards.
        op       = 2'b00;
        gate_tbl = ideal_table(2'b00);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_outputs("midrun_rst");
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (ifc1.done || ifc3.done || ifc1.busy || ifc3.busy) done_seen++;
        end
        chk("post_rst_idle", 8'(done_seen), 8'h0);

        run_case("after_rst", 2'b10, ideal_table(2'b10), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the number of wait cycles between driving a vector and sampling the response; legal range is 1..15.
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  requests a check run; it SHALL be honoured only in IDLE or DONE.
REQ-005 op  input  2  selects the expected function: 00 AND, 01 OR, 10 XOR, 11 NAND; it SHALL be latched when start is accepted.
REQ-006 a_out  output  1  is operand A driven to the gate under test.
REQ-007 b_out  output  1  is operand B driven to the gate under test.
REQ-008 f_in  input  1  is the gate-under-test response.
REQ-009 busy  output  1  SHALL be high in DRIVE, SETTLE and SAMPLE.
REQ-010 done  output  1  SHALL be high in DONE and held until the next accepted start or reset.
REQ-011 pass  output  1  SHALL be high only when done is high and fail_count equals 0.
REQ-012 fail_count  output  3  is the number of mismatching cases, 0..4.
REQ-013 err_mask  output  4  SHALL have bit i set when case i mismatched.
REQ-014 case_idx  output  2  is the current case number.

Function
REQ-015 The state machine SHALL have the states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-016 Case i SHALL drive a_out = i[1] and b_out = i[0], so that cases 0..3 apply AB = 00, 01, 10, 11 in order.
REQ-017 When start is accepted, the block SHALL:
- enter DRIVE on the next cycle;
- clear case_idx, fail_count and err_mask;
- latch op.
REQ-018 DRIVE SHALL last 1 cycle, with a_out and b_out updated from case_idx, then move to SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, using a 4-bit counter, then move to SAMPLE.
REQ-020 SAMPLE SHALL last 1 cycle and compare f_in with the expected value f(op_latched, a_out, b_out).
REQ-021 On a mismatch in SAMPLE, fail_count SHALL increment by 1 and err_mask[case_idx] SHALL be set.
REQ-022 At the end of SAMPLE:
- if case_idx equals 3, the block SHALL go to DONE;
- otherwise case_idx SHALL increment and the block SHALL go to DRIVE.
REQ-023 case_idx SHALL NOT wrap past 3 during a run.
REQ-024 Run latency: done SHALL rise 1 + 4*(2+SETTLE_CYCLES) cycles after the start-accept edge, which is 13 cycles for SETTLE_CYCLES = 1.
REQ-025 a_out and b_out SHALL hold stable from DRIVE through SAMPLE of each case, and SHALL keep the last-case values in DONE.
REQ-026 start while busy is high SHALL be ignored, and op changes during a run SHALL have no effect.
REQ-027 start in DONE SHALL restart the run exactly as from IDLE.
REQ-028 fail_count SHALL saturate at 4; it is 3 bits wide and never exceeds 4 by construction.
REQ-029 An X or Z value on f_in in SAMPLE SHALL be treated as a mismatch in simulation; synthesis behaviour for X/Z is unspecified.

Reset
REQ-030 reset SHALL force the following, taking priority over start and over any state:
- state IDLE;
- a_out = 0 and b_out = 0;
- busy = 0, done = 0, pass = 0;
- fail_count = 0, err_mask = 0, case_idx = 0;
- SETTLE counter = 0.
REQ-031 reset asserted mid-run SHALL abandon the run with no done pulse; after reset is released, a new start SHALL be required.

Configuration
REQ-032 The macro GATE_CHK_STOP_ON_FAIL_EN, when defined, SHALL make the first mismatch in SAMPLE go directly to DONE:
- fail_count is 1;
- err_mask has only that case's bit set;
- case_idx holds the failing case.
REQ-033 When GATE_CHK_STOP_ON_FAIL_EN is not defined, all 4 cases SHALL always run, and done latency SHALL always equal the value in REQ-024.

Verification
REQ-034 reset, then op=00 with an ideal AND model on f_in, then a start pulse -> a_out/b_out sequence 00, 01, 10, 11; done at cycle 13; pass=1; fail_count=0; err_mask=0000.
REQ-035 op=10 with f_in driven as AND instead of XOR -> cases 1, 2 and 3 mismatch; fail_count=3; err_mask=1110; pass=0.
REQ-036 start re-pulsed at cycles 3 and 7 of a run, and op toggled mid-run -> no restart; done at cycle 13; result reflects the op latched at start.
REQ-037 reset asserted at cycle 5 of a run -> all outputs at reset values on the next cycle; done stays 0 until a new start.
REQ-038 SETTLE_CYCLES=3, op=11 with an ideal NAND model -> done at cycle 21; pass=1; after done, a start from DONE reruns with identical results.
REQ-039 GATE_CHK_STOP_ON_FAIL_EN defined, op=01, f_in stuck at 0 -> case 0 matches; case 1 mismatches; done at cycle 7; case_idx=1; fail_count=1; err_mask=0010.
